// File: rtl/fifo_buffer.sv
// Single-clock first-word-fall-through FIFO. The head word is driven combinationally
// on read_data, and a read consumes it at the next rising edge.
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int ADDR      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR:0]         count
);

  // Handshake: a request is taken at the rising edge only when its enable is high
  // and the FIFO can serve it. A write is taken when the FIFO is not full, and a
  // read is taken when it is not empty. A request that cannot be served is dropped
  // and leaves no trace.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR:0]         r_wr_ptr;
  logic [ADDR:0]         r_rd_ptr;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR:0]         w_count;

  // The pointers carry one extra wrap bit. This lets full and empty be told apart
  // when the index bits are equal.
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[ADDR-1:0] == r_rd_ptr[ADDR-1:0]) &&
                       (r_wr_ptr[ADDR] != r_rd_ptr[ADDR]);
  assign w_wr_accept = write_en && !w_full;
  assign w_rd_accept = read_en && !w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset. Stale words are never visible because the
  // pointers gate what can be read.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr[ADDR-1:0]] <= write_data;
  end

  assign read_data = w_empty ? '0 : r_mem[r_rd_ptr[ADDR-1:0]];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = w_count;

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer. A queue models the FIFO contents, and every
// pop, flag and count value is compared against that model.
module tb_fifo_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset_n;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  logic [DW-1:0] exp_q[$];
  int            total_cnt;
  int            bad_cnt;

  fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_head"},  32'(read_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
  endtask

  // driver: apply one cycle of stimulus, update the model, check after the edge
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    logic do_wr;
    logic do_rd;
    logic [DW-1:0] exp_v;
    @(negedge clk);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    do_wr = we && (exp_q.size() != DEPTH);
    do_rd = re && (exp_q.size() != 0);
    if (do_rd) begin
      exp_v = exp_q.pop_front();
      check("pop_data", 32'(read_data), 32'(exp_v));
    end
    if (do_wr) exp_q.push_back(wd);
    @(posedge clk);
    #1;
    check_state("post");
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    write_en   = 1'b0;
    write_data = '0;
    read_en    = 1'b0;
    reset_n    = 1'b0;

    #12;
    check_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // fill with 00,44,88,CC
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i * 8'h44), 1'b0);
    // writes while full are dropped
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b0);
    // drain in order, then read_data returns to 0
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    // reads while empty are ignored
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    // the next word falls through immediately
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // simultaneous read and write at count=2, running past the pointer wrap
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h12 + i), 1'b1);
    // simultaneous read and write when full: only the read is taken
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    // simultaneous read and write when empty: only the write is taken
    while (exp_q.size() != 0) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);

    // reset asserted between clock edges at count=3
    while (exp_q.size() < 3) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_state("async_rst");
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    reset_n  = 1'b1;

    // fresh write/read traffic after reset
    step(1'b1, 8'hE1, 1'b0);
    step(1'b1, 8'hE2, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // random mixed traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
